// File: rtl/pwm_ctrl_if.sv
// Register-write, control and status bundle between a host and pwm_ctrl.
interface pwm_ctrl_if;
   localparam int unsigned PW = 17;
   localparam int unsigned CW = 16;

   logic          wr_en;
   logic [1:0]    wr_addr;
   logic [PW-1:0] wr_data;
   logic          start;
   logic          stop;
   logic          pwm_in;
   logic          pwm_rst;
   logic [PW-1:0] onperiod;
   logic [PW-1:0] offperiod;
   logic          busy;
   logic          done;
   logic          pending;
   logic [CW-1:0] pulse_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, pwm_in,
      input  pwm_rst, onperiod, offperiod, busy, done, pending, pulse_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, pwm_in,
      output pwm_rst, onperiod, offperiod, busy, done, pending, pulse_cnt
   );
endinterface

// File: rtl/pwm_ctrl.sv
// Sequencer for a pwm instance: shadowed period registers applied on falling
// edges of its output, burst counting, and stop with drain to a low level.
module pwm_ctrl (
   input logic       clkin,
   input logic       rst,
   pwm_ctrl_if.slave bus
);
   localparam int unsigned PW = 17;
   localparam int unsigned CW = 16;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [1:0] A_ON     = 2'd0;
   localparam logic [1:0] A_OFF    = 2'd1;
   localparam logic [1:0] A_BURST  = 2'd2;
   localparam logic [1:0] A_COMMIT = 2'd3;

   logic [1:0]    state, state_nxt;
   logic          pwm_d;
   logic          rise, fall;
   logic [PW-1:0] shadow_on, shadow_off;
   logic [CW-1:0] burst;
   logic [PW-1:0] onperiod_q, onperiod_nxt;
   logic [PW-1:0] offperiod_q, offperiod_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          pending_q, pending_nxt;
   logic          done_q, done_nxt;
   logic          busy_q, pwm_rst_q;
   logic          load;

   assign rise = bus.pwm_in & ~pwm_d;
   assign fall = ~bus.pwm_in & pwm_d;

   // Host-visible shadow registers and the edge-detect delay stage
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         shadow_on  <= '0;
         shadow_off <= '0;
         burst      <= '0;
         pwm_d      <= 1'b0;
      end else begin
         pwm_d <= bus.pwm_in;
         if (bus.wr_en) begin
            case (bus.wr_addr)
               A_ON:    shadow_on  <= bus.wr_data;
               A_OFF:   shadow_off <= bus.wr_data;
               A_BURST: burst      <= bus.wr_data[CW-1:0];
               default: ;
            endcase
         end
      end
   end

   // Next-state and next-output logic; a commit written on the same edge as
   // a load re-arms pending so the freshly written shadows still get applied
   always_comb begin
      state_nxt     = state;
      onperiod_nxt  = onperiod_q;
      offperiod_nxt = offperiod_q;
      cnt_nxt       = cnt_q;
      pending_nxt   = pending_q;
      done_nxt      = 1'b0;
      load          = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               load        = 1'b1;
               pending_nxt = 1'b0;
               cnt_nxt     = '0;
               state_nxt   = RUN;
            end
         end
         RUN: begin
            if (rise && (cnt_q != '1)) cnt_nxt = cnt_q + CW'(1);
            if (fall && pending_q) begin
               load        = 1'b1;
               pending_nxt = 1'b0;
            end
            if (fall && (burst != '0) && (cnt_q == burst)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (bus.stop) begin
               if (!bus.pwm_in) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!bus.pwm_in) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (load) begin
         onperiod_nxt  = shadow_on;
         offperiod_nxt = shadow_off;
      end
      if (bus.wr_en && (bus.wr_addr == A_COMMIT)) pending_nxt = 1'b1;
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         onperiod_q  <= '0;
         offperiod_q <= '0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         pwm_rst_q   <= 1'b1;
      end else begin
         state       <= state_nxt;
         onperiod_q  <= onperiod_nxt;
         offperiod_q <= offperiod_nxt;
         cnt_q       <= cnt_nxt;
         pending_q   <= pending_nxt;
         done_q      <= done_nxt;
         busy_q      <= (state_nxt != IDLE);
         pwm_rst_q   <= (state_nxt == IDLE);
      end
   end

   assign bus.onperiod  = onperiod_q;
   assign bus.offperiod = offperiod_q;
   assign bus.pulse_cnt = cnt_q;
   assign bus.pending   = pending_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.pwm_rst   = pwm_rst_q;
endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: directed scenarios plus random traffic, scored against a
// behavioural model driving a simple pwm stand-in for pwm_in.
module tb_pwm_ctrl;
   logic clkin = 1'b0;
   logic rst;
   always #5 clkin = ~clkin;

   pwm_ctrl_if bus ();
   pwm_ctrl dut (.clkin(clkin), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        pwm_rst;
      logic        busy;
      logic        done;
      logic        pending;
      logic [15:0] cnt;
      logic [16:0] on;
      logic [16:0] off;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state (mode: 0 idle, 1 running, 2 draining)
   int          m_mode;
   logic [16:0] m_on, m_off, m_son, m_soff;
   logic [15:0] m_burst, m_cnt;
   logic        m_pend, m_pwmd, m_done;

   // pwm stand-in state
   bit p_first;
   int p_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_on = '0; m_off = '0; m_son = '0; m_soff = '0;
      m_burst = '0; m_cnt = '0; m_pend = 1'b0; m_pwmd = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step(input logic we, input logic [1:0] a, input logic [16:0] d,
                             input logic st, input logic sp, input logic pin);
      bit rise, fall;
      rise   = pin && !m_pwmd;
      fall   = !pin && m_pwmd;
      m_done = 1'b0;
      if (m_mode == 0) begin
         if (st && !sp) begin
            m_on = m_son; m_off = m_soff; m_pend = 1'b0; m_cnt = '0; m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (rise && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (fall && m_pend) begin
            m_on = m_son; m_off = m_soff; m_pend = 1'b0;
         end
         if (fall && m_burst != 0 && m_cnt == m_burst) begin
            m_mode = 0; m_done = 1'b1;
         end else if (sp) begin
            if (!pin) begin m_mode = 0; m_done = 1'b1; end
            else m_mode = 2;
         end
      end else begin
         if (!pin) begin m_mode = 0; m_done = 1'b1; end
      end
      if (we) begin
         if (a == 2'd0) m_son = d;
         if (a == 2'd1) m_soff = d;
         if (a == 2'd2) m_burst = d[15:0];
         if (a == 2'd3) m_pend = 1'b1;
      end
      m_pwmd = pin;
   endtask

   task automatic push_exp();
      exp_t e;
      e.pwm_rst = (m_mode == 0);
      e.busy    = (m_mode != 0);
      e.done    = m_done;
      e.pending = m_pend;
      e.cnt     = m_cnt;
      e.on      = m_on;
      e.off     = m_off;
      exp_q.push_back(e);
   endtask

   function automatic int lim(input logic [16:0] v);
      return (v == 17'd0) ? 1 : int'(v);
   endfunction

   // High for onperiod cycles, low for offperiod cycles, high first after reset
   task automatic pwm_step();
      if (bus.pwm_rst !== 1'b0) begin
         p_first = 1'b1; p_cnt = 0; bus.pwm_in = 1'b0;
      end else if (p_first) begin
         p_first = 1'b0; p_cnt = 1; bus.pwm_in = 1'b1;
      end else if (bus.pwm_in && p_cnt >= lim(bus.onperiod)) begin
         bus.pwm_in = 1'b0; p_cnt = 1;
      end else if (!bus.pwm_in && p_cnt >= lim(bus.offperiod)) begin
         bus.pwm_in = 1'b1; p_cnt = 1;
      end else begin
         p_cnt++;
      end
   endtask

   task automatic cyc(input logic we = 1'b0, input logic [1:0] a = 2'd0,
                      input logic [16:0] d = 17'd0, input logic st = 1'b0,
                      input logic sp = 1'b0, input logic sp_hi = 1'b0);
      @(negedge clkin);
      rst = 1'b1;
      pwm_step();
      bus.wr_en   = we;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.start   = st;
      bus.stop    = sp | (sp_hi & bus.pwm_in);
      model_step(we, a, d, st, bus.stop, bus.pwm_in);
      push_exp();
      @(posedge clkin); #1;
   endtask

   task automatic do_reset();
      @(negedge clkin);
      rst = 1'b0;
      bus.wr_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pwm_in = 1'b0;
      p_first = 1'b1; p_cnt = 0;
      model_reset();
      push_exp();
      #1;
      chk("rst_pwm_rst", bus.pwm_rst, 1);
      chk("rst_on", bus.onperiod, 0);
      chk("rst_off", bus.offperiod, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pending", bus.pending, 0);
      chk("rst_cnt", bus.pulse_cnt, 0);
      @(posedge clkin); #1;
   endtask

   // Scoreboard monitor: one expected snapshot per clock
   initial begin
      exp_t e;
      forever begin
         @(posedge clkin); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pwm_rst", bus.pwm_rst, e.pwm_rst);
            chk("sb_busy", bus.busy, e.busy);
            chk("sb_done", bus.done, e.done);
            chk("sb_pending", bus.pending, e.pending);
            chk("sb_pulse_cnt", bus.pulse_cnt, e.cnt);
            chk("sb_onperiod", bus.onperiod, e.on);
            chk("sb_offperiod", bus.offperiod, e.off);
         end
      end
   end

   initial begin
      int k;
      rst = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.pwm_in = 1'b0;
      p_first = 1'b1; p_cnt = 0;
      model_reset();
      do_reset();

      // Burst of three pulses
      cyc(1, 2'd0, 17'd2); cyc(1, 2'd1, 17'd3); cyc(1, 2'd2, 17'd3);
      cyc(0, 2'd0, 17'd0, 1);
      chk("t1_on", bus.onperiod, 2);
      chk("t1_off", bus.offperiod, 3);
      chk("t1_pwm_rst_low", bus.pwm_rst, 0);
      k = 0;
      while (bus.done !== 1'b1 && k < 40) begin cyc(); k++; end
      chk("t1_done", bus.done, 1);
      chk("t1_cnt", bus.pulse_cnt, 3);
      chk("t1_pwm_rst_high", bus.pwm_rst, 1);
      cyc();
      chk("t1_done_one_cycle", bus.done, 0);

      // Continuous run, commit applied on the next fall
      cyc(1, 2'd2, 17'd0); cyc(0, 2'd0, 17'd0, 1);
      repeat (3) cyc();
      cyc(1, 2'd0, 17'd5); cyc(1, 2'd1, 17'd5); cyc(1, 2'd3, 17'd0);
      chk("t2_pending", bus.pending, 1);
      chk("t2_on_held", bus.onperiod, 2);
      k = 0;
      while (bus.pending === 1'b1 && k < 20) begin cyc(); k++; end
      chk("t2_on_applied", bus.onperiod, 5);
      chk("t2_off_applied", bus.offperiod, 5);
      chk("t2_pending_clr", bus.pending, 0);

      // Stop while high drains until pwm_in goes low
      k = 0;
      do begin cyc(0, 2'd0, 17'd0, 0, 0, 1); k++; end while (bus.stop !== 1'b1 && k < 20);
      chk("t3_drain_busy", bus.busy, 1);
      chk("t3_drain_no_done", bus.done, 0);
      k = 0;
      while (bus.done !== 1'b1 && k < 20) begin cyc(); k++; end
      chk("t3_done", bus.done, 1);
      chk("t3_idle", bus.busy, 0);

      // Same-edge start and shadow write
      cyc(1, 2'd0, 17'd4); cyc(1, 2'd1, 17'd3); cyc(1, 2'd3, 17'd0);
      cyc(1, 2'd0, 17'd9, 1);
      chk("t4_on_old", bus.onperiod, 4);
      chk("t4_pending", bus.pending, 0);
      cyc(1, 2'd3, 17'd0);
      k = 0;
      while (bus.pending === 1'b1 && k < 20) begin cyc(); k++; end
      chk("t4_shadow_new", bus.onperiod, 9);
      cyc(0, 2'd0, 17'd0, 0, 1);
      k = 0;
      while (bus.busy === 1'b1 && k < 30) begin cyc(); k++; end
      chk("t4_stopped", bus.busy, 0);

      // Reset mid-run
      cyc(0, 2'd0, 17'd0, 1);
      k = 0;
      while (bus.pulse_cnt !== 16'd2 && k < 40) begin cyc(); k++; end
      chk("t5_cnt_before", bus.pulse_cnt, 2);
      do_reset();
      repeat (3) begin cyc(); chk("t5_no_done", bus.done, 0); end

      // Start with stop is ignored
      cyc(0, 2'd0, 17'd0, 1, 1);
      chk("t6_busy", bus.busy, 0);
      chk("t6_done", bus.done, 0);
      chk("t6_pwm_rst", bus.pwm_rst, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic       we, st, sp;
         logic [1:0] a;
         logic [16:0] d;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            we = ($urandom_range(0, 2) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = (a == 2'd2) ? 17'($urandom_range(0, 5)) : 17'($urandom_range(0, 6));
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 24) == 0);
            cyc(we, a, d, st, sp);
         end
      end

      @(posedge clkin); #2;
      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 SHALL have port: clkin  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: wr_en  input  1  register write strobe, one write per cycle.
REQ-004 SHALL have port: wr_addr  input  2  register select: 0 shadow on-period, 1 shadow off-period, 2 burst count, 3 commit.
REQ-005 SHALL have port: wr_data  input  17  write data; addr 2 uses bits [15:0]; addr 3 ignores data.
REQ-006 SHALL have port: start  input  1  level-sampled start request.
REQ-007 SHALL have port: stop  input  1  level-sampled stop request.
REQ-008 SHALL have port: pwm_in  input  1  clkout of the controlled pwm instance, synchronous to clkin.
REQ-009 SHALL have port: pwm_rst  output  1  active-high reset to the pwm instance.
REQ-010 SHALL have port: onperiod  output  17  active on-period to the pwm instance.
REQ-011 SHALL have port: offperiod  output  17  active off-period to the pwm instance.
REQ-012 SHALL have port: busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on return to IDLE.
REQ-014 SHALL have port: pending  output  1  committed shadow values not yet applied.
REQ-015 SHALL have port: pulse_cnt  output  16  rising edges of pwm_in since last start.

Function
REQ-016 SHALL hold a 1-cycle registered copy pwm_d of pwm_in; rise = pwm_in & ~pwm_d; fall = ~pwm_in & pwm_d.
REQ-017 SHALL, on wr_en with addr 0/1/2, update the shadow-on, shadow-off or burst register at that edge, in any state.
REQ-018 SHALL, on wr_en with addr 3, set pending at that edge.
REQ-019 SHALL implement states IDLE, RUN, DRAIN.
REQ-020 SHALL, in IDLE, drive pwm_rst=1 and keep onperiod/offperiod at the last active values.
REQ-021 SHALL, in IDLE with start=1 and stop=0: copy pre-edge shadow values into onperiod/offperiod, clear pending, clear pulse_cnt, enter RUN; pwm_rst=0 from the next cycle.
REQ-022 SHALL, for a same-edge start and addr-0/1 write, update the shadow but not copy the new value; pending is unchanged unless addr=3.
REQ-023 SHALL ignore start in RUN and DRAIN, and treat start=1 with stop=1 in IDLE as no action.
REQ-024 SHALL, in RUN, increment pulse_cnt on each rise, saturating at 0xFFFF.
REQ-025 SHALL, in RUN on a fall with pending=1, copy the shadow values into onperiod/offperiod and clear pending at that edge; never at any other time.
REQ-026 SHALL, in RUN on a fall with burst!=0 and pulse_cnt==burst, go to IDLE with done=1; burst is compared live; burst=0 means continuous.
REQ-027 SHALL, in RUN with stop=1, go to IDLE with done=1 if pwm_in=0, else to DRAIN.
REQ-028 SHALL exit DRAIN to IDLE with done=1 on the first cycle where pwm_in=0; the stop level is then ignored.
REQ-029 SHALL give burst-end priority over a same-edge stop; both produce one done pulse.
REQ-030 SHALL hold pulse_cnt after returning to IDLE until the next start.

Reset
REQ-031 SHALL, on rst=0 asynchronously: state=IDLE, pwm_rst=1, onperiod=offperiod=0, shadows=0, burst=0, pending=0, pulse_cnt=0, pwm_d=0, done=0, busy=0.
REQ-032 SHALL, when reset is asserted mid-RUN or mid-DRAIN, abort without a done pulse.

Verification
REQ-033 Test 1: write on=2, off=3, burst=3, then start -> outputs 2/3, pwm_rst falls 1 cycle later, done after 3rd fall, pulse_cnt=3, pwm_rst=1.
REQ-034 Test 2: in RUN, write on=5, off=5, then commit -> pending=1, outputs unchanged until next fall, then 5/5 and pending=0.
REQ-035 Test 3: burst=0, stop while pwm_in=1 -> DRAIN, busy=1 until pwm_in=0, then done pulse and IDLE.
REQ-036 Test 4: start and write addr 0 = 9 on the same edge -> onperiod takes the old shadow, shadow=9, pending=0.
REQ-037 Test 5: rst low mid-RUN with pulse_cnt=2 -> all outputs at reset values immediately, no done pulse.
REQ-038 Test 6: start and stop together in IDLE -> stays IDLE, busy=0, done=0.
